// File: rtl/bicubic_pkg.sv
// Shared FSM state type and fixed-point helpers for the Catmull-Rom bicubic interpolator.
package bicubic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WGT,
        ROW0,
        ROW1,
        ROW2,
        ROW3,
        COL,
        OUT
    } state_t;

    localparam int unsigned HELPER_W = 32;

    typedef logic signed [HELPER_W-1:0] cr_coef_t;

    typedef struct packed {
        cr_coef_t d3;
        cr_coef_t d2;
        cr_coef_t d1;
        cr_coef_t d0;
    } cr_wgt_t;

    // Doubled Catmull-Rom weights for Q0.frac_w fraction t; they always sum to 2 << frac_w.
    function automatic cr_wgt_t cr_weights(input logic [HELPER_W-1:0] t, input int unsigned frac_w);
        logic signed [63:0] ts;
        logic signed [63:0] t2;
        logic signed [63:0] t3;
        logic signed [63:0] one;
        logic signed [63:0] half;
        cr_wgt_t            w;
        ts   = $signed({32'd0, t});
        one  = 64'sd1 <<< frac_w;
        half = 64'sd1 <<< (frac_w - 1);
        t2   = (ts * ts + half) >>> frac_w;
        t3   = (t2 * ts + half) >>> frac_w;
        w.d0 = HELPER_W'(64'sd2 * t2 - t3 - ts);
        w.d1 = HELPER_W'(64'sd3 * t3 - 64'sd5 * t2 + 64'sd2 * one);
        w.d2 = HELPER_W'(64'sd4 * t2 + ts - 64'sd3 * t3);
        w.d3 = HELPER_W'(t3 - t2);
        return w;
    endfunction

    // Saturate a signed value into the unsigned pix_w-bit pixel range.
    function automatic logic [HELPER_W-1:0] clamp_pix(input logic signed [63:0] v, input int unsigned pix_w);
        logic signed [63:0]  maxv;
        logic [HELPER_W-1:0] r;
        maxv = (64'sd1 <<< pix_w) - 64'sd1;
        if (v < 64'sd0) begin
            r = '0;
        end else if (v > maxv) begin
            r = HELPER_W'(maxv);
        end else begin
            r = HELPER_W'(v);
        end
        return r;
    endfunction

endpackage

// File: rtl/bicubic_mac4.sv
// Combinational 4-tap signed dot product with round-half-up and pixel clamp.
module bicubic_mac4
    import bicubic_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic [4*(FRAC_W+4)-1:0] wgt,
    input  logic [4*PIX_W-1:0]      pix,
    output logic [PIX_W-1:0]        res_c
);

    localparam int unsigned WW    = FRAC_W + 4;
    localparam int unsigned ACC_W = PIX_W + FRAC_W + 8;

    logic signed [ACC_W-1:0] acc_c;
    logic signed [ACC_W-1:0] rnd_c;
    logic [HELPER_W-1:0]     clamp_c;
    logic                    unused_c;

    always_comb begin
        acc_c = '0;
        for (int k = 0; k < 4; k++) begin
            acc_c = acc_c + ACC_W'($signed(wgt[k*WW +: WW]) * $signed({1'b0, pix[k*PIX_W +: PIX_W]}));
        end
        // Weights are doubled, so the result scale is 2^(FRAC_W+1).
        rnd_c   = (acc_c + (ACC_W'(1) <<< FRAC_W)) >>> (FRAC_W + 1);
        clamp_c = clamp_pix(64'(rnd_c), PIX_W);
        res_c   = clamp_c[PIX_W-1:0];
    end

    assign unused_c = ^clamp_c[HELPER_W-1:PIX_W];

endmodule

// File: rtl/bicubic_interp_core.sv
// Catmull-Rom bicubic interpolator: 4x4 window in, one clamped pixel out, one shared MAC.
// Define BICUBIC_FASTPATH_EN to skip the MAC passes when both fractions are zero.
module bicubic_interp_core
    import bicubic_pkg::*;
#(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*PIX_W-1:0] in_pix,
    input  logic [FRAC_W-1:0]   in_fx,
    input  logic [FRAC_W-1:0]   in_fy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    out_pix
);

    localparam int unsigned WW    = FRAC_W + 4;
    localparam int unsigned ROW_W = 4 * PIX_W;

    state_t              state;
    state_t              state_d;
    logic [16*PIX_W-1:0] pix_q;
    logic [FRAC_W-1:0]   fx_q;
    logic [FRAC_W-1:0]   fy_q;
    logic [4*WW-1:0]     wx_q;
    logic [4*WW-1:0]     wy_q;
    logic [4*WW-1:0]     wx_c;
    logic [4*WW-1:0]     wy_c;
    logic [ROW_W-1:0]    mid_q;
    logic [4*WW-1:0]     mac_wgt_c;
    logic [ROW_W-1:0]    mac_pix_c;
    logic [PIX_W-1:0]    mac_res_c;
    logic                in_fire_c;
    logic                fast_c;
    cr_wgt_t             wx_s;
    cr_wgt_t             wy_s;
    logic                unused_wgt_c;

    assign in_fire_c = in_valid && in_ready;

`ifdef BICUBIC_FASTPATH_EN
    assign fast_c = (in_fx == '0) && (in_fy == '0);
`else
    assign fast_c = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_fire_c) state_d = fast_c ? OUT : WGT;
            WGT:     state_d = ROW0;
            ROW0:    state_d = ROW1;
            ROW1:    state_d = ROW2;
            ROW2:    state_d = ROW3;
            ROW3:    state_d = COL;
            COL:     state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Weights are narrowed from the wide helper; upper bits are pure sign extension.
    always_comb begin
        wx_s = cr_weights(HELPER_W'(fx_q), FRAC_W);
        wy_s = cr_weights(HELPER_W'(fy_q), FRAC_W);
        wx_c = {wx_s.d3[WW-1:0], wx_s.d2[WW-1:0], wx_s.d1[WW-1:0], wx_s.d0[WW-1:0]};
        wy_c = {wy_s.d3[WW-1:0], wy_s.d2[WW-1:0], wy_s.d1[WW-1:0], wy_s.d0[WW-1:0]};
    end

    assign unused_wgt_c = ^{wx_s.d3[HELPER_W-1:WW], wx_s.d2[HELPER_W-1:WW],
                            wx_s.d1[HELPER_W-1:WW], wx_s.d0[HELPER_W-1:WW],
                            wy_s.d3[HELPER_W-1:WW], wy_s.d2[HELPER_W-1:WW],
                            wy_s.d1[HELPER_W-1:WW], wy_s.d0[HELPER_W-1:WW]};

    // Shared MAC operand select: one row per ROWr state, then the mid column.
    always_comb begin
        mac_wgt_c = wx_q;
        mac_pix_c = pix_q[0 +: ROW_W];
        case (state)
            ROW1:    mac_pix_c = pix_q[ROW_W +: ROW_W];
            ROW2:    mac_pix_c = pix_q[2*ROW_W +: ROW_W];
            ROW3:    mac_pix_c = pix_q[3*ROW_W +: ROW_W];
            COL: begin
                mac_wgt_c = wy_q;
                mac_pix_c = mid_q;
            end
            default: ;
        endcase
    end

    bicubic_mac4 #(
        .PIX_W  (PIX_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .wgt   (mac_wgt_c),
        .pix   (mac_pix_c),
        .res_c (mac_res_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == OUT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q   <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            mid_q   <= '0;
            out_pix <= '0;
        end else begin
            case (state)
                IDLE: if (in_fire_c) begin
                    pix_q <= in_pix;
                    fx_q  <= in_fx;
                    fy_q  <= in_fy;
                    if (fast_c) out_pix <= in_pix[5*PIX_W +: PIX_W];
                end
                WGT: begin
                    wx_q <= wx_c;
                    wy_q <= wy_c;
                end
                ROW0:    mid_q[0 +: PIX_W]       <= mac_res_c;
                ROW1:    mid_q[PIX_W +: PIX_W]   <= mac_res_c;
                ROW2:    mid_q[2*PIX_W +: PIX_W] <= mac_res_c;
                ROW3:    mid_q[3*PIX_W +: PIX_W] <= mac_res_c;
                COL:     out_pix                 <= mac_res_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_interp_core.sv
// Scoreboard bench for bicubic_interp_core; builds with or without BICUBIC_FASTPATH_EN.
`timescale 1ns/1ps
module tb_bicubic_interp_core;

    localparam int unsigned PW = 8;
    localparam int unsigned FW = 8;
`ifdef BICUBIC_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    // Counting the transfer edge as edge N+1, out_valid rises on edge N+7 (full) or N+1 (fast).
    localparam int LAT_FULL = 6;
    localparam int LAT_FAST = 0;

    typedef struct {
        logic [PW-1:0] pix;
        int            xfer;
        int            lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [16*PW-1:0] in_pix;
    logic [FW-1:0]    in_fx;
    logic [FW-1:0]    in_fy;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_pix;

    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;
    bit               presenting = 1'b0;
    bit               chk_ready_next = 1'b0;
    exp_t             sb[$];
    logic [16*PW-1:0] rand_win;

    bicubic_interp_core #(
        .PIX_W  (PW),
        .FRAC_W (FW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_fx     (in_fx),
        .in_fy     (in_fy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16*PW-1:0] rows_same(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                                   input logic [PW-1:0] c, input logic [PW-1:0] d);
        logic [16*PW-1:0] w;
        for (int r = 0; r < 4; r++) begin
            w[(r*4+0)*PW +: PW] = a;
            w[(r*4+1)*PW +: PW] = b;
            w[(r*4+2)*PW +: PW] = c;
            w[(r*4+3)*PW +: PW] = d;
        end
        return w;
    endfunction

    function automatic logic [16*PW-1:0] rows_const(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                                    input logic [PW-1:0] c, input logic [PW-1:0] d);
        logic [16*PW-1:0] w;
        logic [PW-1:0]    v [4];
        v[0] = a;
        v[1] = b;
        v[2] = c;
        v[3] = d;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                w[(r*4+k)*PW +: PW] = v[r];
            end
        end
        return w;
    endfunction

    // Present one window; the expected result is queued just before the transfer edge.
    task automatic send(input logic [16*PW-1:0] p, input logic [FW-1:0] fx, input logic [FW-1:0] fy,
                        input logic [PW-1:0] want, input bit track);
        int   n;
        exp_t e;
        in_pix   = p;
        in_fx    = fx;
        in_fy    = fy;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        if (in_ready) begin
            if (track) begin
                e.pix  = want;
                e.xfer = cyc + 1;
                e.lat  = (FAST && fx == '0 && fy == '0) ? LAT_FAST : LAT_FULL;
                sb.push_back(e);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Monitor: compares every presented output against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_ready_next) begin
                check("in_ready_after_out", in_ready, 1);
                chk_ready_next = 1'b0;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid: got out_pix %0d with nothing expected (cycle %0d)",
                             out_pix, cyc);
                end else begin
                    if (!presenting) begin
                        presenting = 1'b1;
                        check("latency", cyc - sb[0].xfer, sb[0].lat);
                    end
                    check("out_pix", out_pix, sb[0].pix);
                    check("in_ready_while_out", in_ready, 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        presenting     = 1'b0;
                        chk_ready_next = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pix    = '0;
        in_fx     = '0;
        in_fy     = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pix", out_pix, 0);
        rst = 1'b0;
        tick();

        send(rows_same(8'h80, 8'h80, 8'h80, 8'h80), 8'h37, 8'hC1, 8'h80, 1'b1);
        drain();
        send(rows_same(8'd0, 8'd64, 8'd128, 8'd192), 8'h80, 8'h80, 8'h60, 1'b1);
        drain();
        send(rows_same(8'd0, 8'd255, 8'd255, 8'd0), 8'h80, 8'h00, 8'hFF, 1'b1);
        drain();
        send(rows_same(8'd255, 8'd0, 8'd0, 8'd255), 8'h80, 8'h00, 8'h00, 1'b1);
        drain();
        send(rows_const(8'd0, 8'd64, 8'd128, 8'd192), 8'h37, 8'h80, 8'h60, 1'b1);
        drain();
        // t=0x40 gives D = [-36, 444, 116, -12]: 40960/512 = 80, and 348/512 rounds up to 1.
        send(rows_same(8'd0, 8'd64, 8'd128, 8'd192), 8'h40, 8'h00, 8'h50, 1'b1);
        drain();
        send(rows_same(8'd0, 8'd0, 8'd3, 8'd0), 8'h40, 8'h00, 8'h01, 1'b1);
        drain();

        for (int i = 0; i < 16; i++) rand_win[i*PW +: PW] = PW'($urandom_range(0, 255));
        send(rand_win, 8'h00, 8'h00, rand_win[5*PW +: PW], 1'b1);
        drain();

        // Back-to-back windows exercise the minimum initiation interval.
        send(rows_same(8'd0, 8'd64, 8'd128, 8'd192), 8'h80, 8'h80, 8'h60, 1'b1);
        send(rows_const(8'd0, 8'd64, 8'd128, 8'd192), 8'h11, 8'h40, 8'h50, 1'b1);
        drain();

        out_ready = 1'b0;
        send(rows_same(8'd0, 8'd64, 8'd128, 8'd192), 8'h80, 8'h80, 8'h60, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_out_valid", out_valid, 1);
        repeat (5) tick();
        out_ready = 1'b1;
        drain();

        // Reset while the window is in ROW2: result must be dropped.
        send(rows_same(8'd0, 8'd64, 8'd128, 8'd192), 8'h80, 8'h80, 8'h60, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_pix", out_pix, 0);
        send(rows_const(8'd0, 8'd64, 8'd128, 8'd192), 8'h40, 8'h40, 8'h50, 1'b1);
        drain();
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
